// File: rtl/cbs_pkg.sv
// Shared definitions for the credit-based shaper slice.
// Holds the byte cost in Q.16 credit units, the FSM state encoding and the
// guard width used by the saturating credit accumulator.
package cbs_pkg;

  // Number of fractional bits in credit and idle_slope values.
  localparam int FRAC_BITS = 16;

  // Credit spent for one accepted byte: 1.0 in Q.16.
  localparam int BYTE_COST = 1 << FRAC_BITS;

  // One extra sign bit is enough to see overflow of credit + slope - cost,
  // since both slope and cost are at most 1.0 (needs CREDIT_WIDTH >= 18).
  localparam int SAT_GUARD_BITS = 1;

  // Shaper state encoding, also visible on the shaper_state output.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] TX   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_WAIT = WAIT,
    ST_TX   = TX
  } cbs_state_e;

endpackage

// File: rtl/cbs_credit_accumulator.sv
// Signed saturating credit accumulator.
// Each cycle the credit moves by +i_add and, when i_sub_byte is set, by minus
// one byte cost. The sum is formed one bit wider than the register and then
// saturated, so the credit never wraps.
// Ports:
//   clk, rstn        clock and synchronous active-low reset
//   i_add            unsigned gain for this cycle (Q1.16)
//   i_sub_byte       charge one byte cost this cycle
//   i_clear          force the credit to zero next cycle
//   i_clamp_to_zero  limit the result to at most zero (positive credit dropped)
//   o_credit         registered signed credit
module cbs_credit_accumulator
  import cbs_pkg::*;
#(
  parameter int CREDIT_WIDTH = 32,
  parameter int SLOPE_WIDTH  = 17
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [SLOPE_WIDTH-1:0]         i_add,
  input  logic                           i_sub_byte,
  input  logic                           i_clear,
  input  logic                           i_clamp_to_zero,
  output logic signed [CREDIT_WIDTH-1:0] o_credit
);

  localparam int SUM_WIDTH = CREDIT_WIDTH + SAT_GUARD_BITS;
  localparam logic signed [CREDIT_WIDTH-1:0] CREDIT_MAX = {1'b0, {(CREDIT_WIDTH-1){1'b1}}};
  localparam logic signed [CREDIT_WIDTH-1:0] CREDIT_MIN = {1'b1, {(CREDIT_WIDTH-1){1'b0}}};

  logic signed [CREDIT_WIDTH-1:0] r_credit;
  logic signed [SUM_WIDTH-1:0]    w_credit_ext;
  logic signed [SUM_WIDTH-1:0]    w_add_ext;
  logic signed [SUM_WIDTH-1:0]    w_cost_ext;
  logic signed [SUM_WIDTH-1:0]    w_sum;
  logic signed [CREDIT_WIDTH-1:0] w_sat;
  logic signed [CREDIT_WIDTH-1:0] w_next;

  always_comb begin
    w_credit_ext = SUM_WIDTH'(r_credit);
    w_add_ext    = SUM_WIDTH'({1'b0, i_add});
    w_cost_ext   = i_sub_byte ? SUM_WIDTH'(BYTE_COST) : '0;
    w_sum        = w_credit_ext + w_add_ext - w_cost_ext;

    // Guard bit disagreeing with the register sign bit means overflow.
    if (w_sum[SUM_WIDTH-1] != w_sum[CREDIT_WIDTH-1]) begin
      w_sat = w_sum[SUM_WIDTH-1] ? CREDIT_MIN : CREDIT_MAX;
    end else begin
      w_sat = w_sum[CREDIT_WIDTH-1:0];
    end

    // With clamping, a positive start can only give a positive result, so
    // min(result, 0) also covers "positive credit is discarded".
    if (i_clamp_to_zero && !w_sat[CREDIT_WIDTH-1]) begin
      w_next = '0;
    end else begin
      w_next = w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_credit <= '0;
    end else begin
      r_credit <= w_next;
    end
  end

  assign o_credit = r_credit;

endmodule

// File: rtl/cbs_credit_shaper.sv
// Per-class credit-based shaper in front of one input of the strict-priority
// frame arbiter. A frame is held at its first beat while credit is negative;
// once its first beat is accepted the rest of the frame passes untouched.
// The data path is a zero-latency combinational copy; only the handshake is
// gated.
// Ports:
//   clk, rstn          clock (one byte-time per cycle), synchronous active-low reset
//   cbs_enable         1 = shaping, 0 = transparent pass-through
//   idle_slope         credit gain per cycle, Q1.16, sampled every cycle
//   s_axis_*           queue-side AXI4-Stream slave (8-bit data, tlast, tuser)
//   m_axis_*           arbiter-side AXI4-Stream master
//   credit             registered signed credit, Q(CREDIT_WIDTH-16).16 bytes
//   shaper_state       current FSM state (IDLE=0, WAIT=1, TX=2)
module cbs_credit_shaper
  import cbs_pkg::*;
#(
  parameter int CREDIT_WIDTH = 32,
  parameter int SLOPE_WIDTH  = 17
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cbs_enable,
  input  logic [SLOPE_WIDTH-1:0]         idle_slope,
  input  logic [7:0]                     s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tuser,
  output logic [7:0]                     m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic signed [CREDIT_WIDTH-1:0] credit,
  output logic [1:0]                     shaper_state
);

  cbs_state_e                     r_state;
  logic                           r_in_frame;
  logic                           w_open;
  logic                           w_beat;
  logic                           w_clamp;
  logic signed [CREDIT_WIDTH-1:0] w_credit;

  // Gate only the first beat of a frame: inside a frame, or with shaping
  // off, the stream always flows; otherwise non-negative credit is required.
  assign w_open = r_in_frame | ~cbs_enable | ~w_credit[CREDIT_WIDTH-1];

  assign m_axis_tvalid = s_axis_tvalid & w_open;
  assign s_axis_tready = m_axis_tready & w_open;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = s_axis_tuser;

  assign w_beat = m_axis_tvalid & m_axis_tready;

  // Idle with nothing accepted: the credit may only recover towards zero,
  // never bank positive credit for a future frame.
  assign w_clamp = (r_state == ST_IDLE) & ~w_beat;

  cbs_credit_accumulator #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .SLOPE_WIDTH  (SLOPE_WIDTH)
  ) u_credit_accumulator (
    .clk             (clk),
    .rstn            (rstn),
    .i_add           (idle_slope),
    .i_sub_byte      (w_beat),
    .i_clear         (~cbs_enable),
    .i_clamp_to_zero (w_clamp),
    .o_credit        (w_credit)
  );

  // Frame tracking runs regardless of cbs_enable so re-enabling shaping in
  // the middle of a frame never splits it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_in_frame <= 1'b0;
    end else begin
      if (w_beat) begin
        r_in_frame <= ~s_axis_tlast;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_beat && !s_axis_tlast) begin
            r_state <= ST_TX;
          end else if (s_axis_tvalid && !w_beat) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_beat) begin
            r_state <= s_axis_tlast ? ST_IDLE : ST_TX;
          end
        end
        ST_TX: begin
          // A frame queued right behind this one passes through IDLE and
          // moves to WAIT on the following cycle.
          if (w_beat && s_axis_tlast) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign credit       = w_credit;
  assign shaper_state = r_state;

endmodule

// File: tb/tb_cbs_credit_shaper.sv
// Self-checking bench for cbs_credit_shaper.
// A source process feeds AXI4-Stream frames from a queue; every queued beat is
// also pushed to a scoreboard queue and popped by a monitor whenever the DUT
// presents a beat downstream. The monitor also runs a frame-level reference
// model of the gate and credit rules and compares handshake, credit and state
// every cycle. Directed scenarios are followed by randomized traffic.
module tb_cbs_credit_shaper;

  localparam int CW = 20;
  localparam int SW = 17;
  localparam longint CREDIT_MAX = (longint'(1) <<< (CW - 1)) - 1;
  localparam longint CREDIT_MIN = -(longint'(1) <<< (CW - 1));
  localparam longint ONE_BYTE   = 65536;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic                 clk;
  logic                 rstn;
  logic                 cbs_enable;
  logic [SW-1:0]        idle_slope;
  logic [7:0]           s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_axis_tlast;
  logic                 s_axis_tuser;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic                 m_axis_tuser;
  logic signed [CW-1:0] credit;
  logic [1:0]           shaper_state;

  cbs_credit_shaper #(
    .CREDIT_WIDTH (CW),
    .SLOPE_WIDTH  (SW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cbs_enable    (cbs_enable),
    .idle_slope    (idle_slope),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .credit        (credit),
    .shaper_state  (shaper_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  beat_t srcQ[$];
  beat_t expQ[$];
  bit    presenting = 0;
  int    gapPct     = 0;
  int    readyPct   = 100;
  bit    randReady  = 0;
  bit    randSlope  = 0;

  // Values sampled at the falling edge by the stimulus driver.
  bit                   hs;
  bit                   capValid;
  bit                   capBeat;
  bit                   capLast;
  logic signed [CW-1:0] capCredit;
  logic [1:0]           capState;

  // Reference model state: credit as a plain integer, plus whether a frame is
  // under way and whether a first beat is being held back.
  longint mCredit  = 0;
  bit     mInFrame = 0;
  bit     mPending = 0;

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic longint satCredit(input longint v);
    if (v > CREDIT_MAX) return CREDIT_MAX;
    if (v < CREDIT_MIN) return CREDIT_MIN;
    return v;
  endfunction

  // Monitor: compares the DUT against the model each cycle and drains the
  // scoreboard on every downstream beat, then advances the model.
  initial begin
    bit     expOpen;
    bit     expValid;
    bit     expBeat;
    longint slopeL;
    longint nc;
    beat_t  b;
    @(posedge clk);
    forever begin
      @(negedge clk);
      expOpen  = mInFrame || !cbs_enable || (mCredit >= 0);
      expValid = s_axis_tvalid && expOpen;
      expBeat  = expValid && m_axis_tready;
      checkOutput("m_tvalid", m_axis_tvalid, expValid);
      checkOutput("s_tready", s_axis_tready, m_axis_tready && expOpen);
      checkOutput("credit", credit, mCredit);
      checkOutput("state", shaper_state, mInFrame ? 2 : (mPending ? 1 : 0));
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL beat_unexpected: got a beat, expected none at %0t", $time);
        end else begin
          b = expQ.pop_front();
          checkOutput("tdata", m_axis_tdata, b.data);
          checkOutput("tlast", m_axis_tlast, b.last);
          checkOutput("tuser", m_axis_tuser, b.user);
        end
      end

      if (!rstn) begin
        mCredit  = 0;
        mInFrame = 0;
        mPending = 0;
      end else begin
        slopeL = longint'(idle_slope);
        if (!cbs_enable) begin
          nc = 0;
        end else if (mInFrame || expBeat) begin
          nc = satCredit(mCredit + slopeL - (expBeat ? ONE_BYTE : 0));
        end else if (mPending) begin
          nc = satCredit(mCredit + slopeL);
        end else if (mCredit > 0) begin
          nc = 0;
        end else begin
          nc = (mCredit + slopeL > 0) ? 0 : mCredit + slopeL;
        end
        mCredit = nc;
        if (expBeat) begin
          mInFrame = !s_axis_tlast;
          mPending = 0;
        end else if (!mInFrame && (mPending || s_axis_tvalid)) begin
          mPending = 1;
        end
      end
    end
  end

  // One clock of stimulus: sample at the falling edge, then update the
  // source and knobs just after the rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    hs        = s_axis_tvalid && s_axis_tready;
    capValid  = m_axis_tvalid;
    capBeat   = m_axis_tvalid && m_axis_tready;
    capLast   = m_axis_tlast;
    capCredit = credit;
    capState  = shaper_state;
    @(posedge clk);
    #1;
    if (hs && presenting) begin
      void'(srcQ.pop_front());
      presenting = 0;
    end
    if (!presenting && srcQ.size() > 0 && $urandom_range(99) >= gapPct) presenting = 1;
    s_axis_tvalid = presenting;
    if (presenting) begin
      s_axis_tdata = srcQ[0].data;
      s_axis_tlast = srcQ[0].last;
      s_axis_tuser = srcQ[0].user;
    end else begin
      s_axis_tdata = 8'($urandom);
      s_axis_tlast = 1'($urandom);
      s_axis_tuser = 1'($urandom);
    end
    if (randReady) m_axis_tready = ($urandom_range(99) < readyPct);
    if (randSlope) idle_slope = SW'($urandom_range(65536, 0));
  endtask

  task automatic pushFrame(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      b.last = (i == len - 1);
      b.user = 1'($urandom);
      srcQ.push_back(b);
      expQ.push_back(b);
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    applyStimulus();
    rstn = 1'b1;
  endtask

  task automatic waitBeats(input int n, input int bound);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < bound) begin
      applyStimulus();
      cyc++;
      if (capBeat) cnt++;
    end
    checkOutput("wait_beats", cnt, n);
  endtask

  task automatic waitLast(input int bound);
    bit got = 0;
    int cyc = 0;
    while (!got && cyc < bound) begin
      applyStimulus();
      cyc++;
      if (capBeat && capLast) got = 1;
    end
    checkOutput("wait_last", got, 1);
  endtask

  task automatic drain(input int bound);
    int cyc = 0;
    while (srcQ.size() > 0 && cyc < bound) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("drain_done", srcQ.size(), 0);
  endtask

  initial begin
    int     n;
    int     cyc;
    longint c1;
    rstn          = 1'b0;
    cbs_enable    = 1'b0;
    idle_slope    = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) applyStimulus();
    rstn = 1'b1;

    // Pass-through: 64 back-to-back beats with shaping off.
    $display("[TB] pass-through frame");
    idle_slope    = SW'(17'h04000);
    m_axis_tready = 1'b1;
    pushFrame(64);
    waitBeats(1, 20);
    n   = 1;
    cyc = 1;
    while (!(capBeat && capLast) && cyc < 200) begin
      applyStimulus();
      cyc++;
      if (capBeat) n++;
    end
    checkOutput("passthru_beats", n, 64);
    checkOutput("passthru_cycles", cyc, 64);
    checkOutput("passthru_credit", capCredit, 0);

    // Debt after an 8-byte frame holds the next frame for 24 cycles.
    $display("[TB] back-to-back frames at slope 0x4000");
    cbs_enable = 1'b1;
    doReset();
    pushFrame(8);
    pushFrame(8);
    waitLast(30);
    applyStimulus();
    checkOutput("debt_credit", capCredit, -393216);
    n = 0;
    while (!capValid && n < 100) begin
      n++;
      applyStimulus();
    end
    checkOutput("gate_cycles", n, 24);
    checkOutput("gate_open_credit", capCredit, 0);
    waitLast(30);

    // Credit earned while the arbiter withholds tready in WAIT.
    $display("[TB] arbiter backpressure in WAIT at slope 0x8000");
    idle_slope    = SW'(17'h08000);
    m_axis_tready = 1'b0;
    doReset();
    pushFrame(3);
    repeat (12) applyStimulus();
    m_axis_tready = 1'b1;
    applyStimulus();
    checkOutput("wait_credit", capCredit, 327680);
    checkOutput("wait_first_beat", capBeat, 1);
    waitLast(10);
    applyStimulus();
    checkOutput("after_frame_credit", capCredit, 229376);
    applyStimulus();
    checkOutput("idle_discard", capCredit, 0);

    // Stall inside a frame gains slope without byte cost.
    $display("[TB] mid-frame stall at slope 0x4000");
    idle_slope = SW'(17'h04000);
    doReset();
    pushFrame(10);
    waitBeats(3, 20);
    m_axis_tready = 1'b0;
    applyStimulus();
    c1 = longint'(capCredit);
    checkOutput("stall_start_credit", c1, -147456);
    checkOutput("stall_no_beat", capBeat, 0);
    repeat (4) applyStimulus();
    m_axis_tready = 1'b1;
    applyStimulus();
    checkOutput("stall_gain", longint'(capCredit) - c1, 81920);
    waitLast(20);

    // Saturation at both ends of a 20-bit credit.
    $display("[TB] credit saturation");
    idle_slope    = SW'(17'h10000);
    m_axis_tready = 1'b0;
    doReset();
    pushFrame(1);
    repeat (22) applyStimulus();
    checkOutput("sat_max", capCredit, 524287);
    m_axis_tready = 1'b1;
    waitLast(5);
    idle_slope = '0;
    doReset();
    pushFrame(12);
    waitLast(30);
    applyStimulus();
    checkOutput("sat_min", capCredit, -524288);

    // Reset in the middle of a frame; remaining beats form a new frame.
    $display("[TB] reset during TX");
    idle_slope = SW'(17'h04000);
    doReset();
    pushFrame(10);
    waitBeats(3, 20);
    rstn = 1'b0;
    applyStimulus();
    rstn = 1'b1;
    applyStimulus();
    checkOutput("post_reset_credit", capCredit, 0);
    checkOutput("post_reset_state", capState, 0);
    checkOutput("post_reset_beat", capBeat, 1);
    waitLast(20);
    applyStimulus();
    checkOutput("reset_frame_idle", capState, 0);

    // Randomized traffic, with enable changed only while the queue is empty.
    $display("[TB] randomized traffic");
    randReady = 1;
    randSlope = 1;
    readyPct  = 70;
    gapPct    = 20;
    for (int seg = 0; seg < 4; seg++) begin
      cbs_enable = (seg != 1);
      for (int c = 0; c < 300; c++) begin
        if (srcQ.size() < 4 && $urandom_range(3) == 0) pushFrame($urandom_range(12, 1));
        applyStimulus();
      end
      drain(3000);
    end
    repeat (2) applyStimulus();
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
